// File: rtl/frv_mmio_arbiter.sv
// frv_mmio_arbiter
// Two-port arbiter and sequencer for the timer/counter MMIO target.
// Port 0 is the core load/store unit, port 1 the debug/host path. One
// single-cycle mmio_en access is in flight at a time. Each transaction runs
// IDLE (grant) -> ISSUE (strobe) -> RESP (response). A short lock keeps a
// hi/lo word pair from one requester together.

module frv_mmio_arbiter #(
   parameter int unsigned LOCK_TIMEOUT = 8  // idle cycles a lock survives an absent owner, 1..255
) (
   input  logic        g_clk,
   input  logic        g_reset,

   input  logic        req0,
   input  logic        wen0,
   input  logic        lock0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,

   input  logic        req1,
   input  logic        wen1,
   input  logic        lock1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,

   output logic        gnt0,
   output logic        gnt1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,

   output logic        mmio_en,
   output logic        mmio_wen,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_wdata,
   input  logic [31:0] mmio_rdata,
   input  logic        mmio_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // The lock is released once the counter has seen LOCK_TIMEOUT absent cycles,
   // i.e. when the count entering a cycle is LOCK_TIMEOUT-1.
   localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t      state_q,      state_d;
   logic        prio_q,       prio_d;       // port that wins a tie
   logic        locked_q,     locked_d;     // locked mode active
   logic        owner_q,      owner_d;      // lock owner port
   logic [7:0]  lock_cnt_q,   lock_cnt_d;   // owner-absent idle cycles
   logic        port_q,       port_d;       // port of the transaction in flight
   logic        lock_q,       lock_d;       // lock request of that transaction
   logic        mmio_en_q,    mmio_en_d;
   logic        mmio_wen_q,   mmio_wen_d;
   logic [31:0] mmio_addr_q,  mmio_addr_d;
   logic [31:0] mmio_wdata_q, mmio_wdata_d;

   // ------------------------------------------------------------------
   // Arbitration terms
   // ------------------------------------------------------------------
   logic in_idle;
   logic in_resp;
   logic elig0;
   logic elig1;
   logic win_port;
   logic grant;
   logic owner_req;
   logic owner_absent;

   assign in_idle  = (state_q == ST_IDLE);
   assign in_resp  = (state_q == ST_RESP);

   // In locked mode only the owner may be granted.
   assign elig0    = req0 && (!locked_q || !owner_q);
   assign elig1    = req1 && (!locked_q ||  owner_q);

   // A lone eligible requester wins; on a tie prio decides.
   assign win_port = (elig0 && elig1) ? prio_q : elig1;
   assign grant    = in_idle && (elig0 || elig1);

   assign owner_req    = owner_q ? req1 : req0;
   assign owner_absent = in_idle && locked_q && !owner_req;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // Compute the next value of every register from the FSM state and inputs.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d      = state_q;
      prio_d       = prio_q;
      locked_d     = locked_q;
      owner_d      = owner_q;
      lock_cnt_d   = lock_cnt_q;
      port_d       = port_q;
      lock_d       = lock_q;
      mmio_en_d    = 1'b0;
      mmio_wen_d   = mmio_wen_q;
      mmio_addr_d  = mmio_addr_q;
      mmio_wdata_d = mmio_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            // Count idle cycles in which the lock owner is not requesting.
            if (owner_absent) begin
               if (lock_cnt_q != 8'hFF) begin
                  lock_cnt_d = lock_cnt_q + 8'd1;
               end
               if (lock_cnt_q >= TIMEOUT_LAST) begin
                  locked_d = 1'b0;
                  prio_d   = !owner_q;
               end
            end

            if (grant) begin
               state_d      = ST_ISSUE;
               mmio_en_d    = 1'b1;
               port_d       = win_port;
               lock_d       = win_port ? lock1  : lock0;
               mmio_wen_d   = win_port ? wen1   : wen0;
               mmio_addr_d  = win_port ? addr1  : addr0;
               mmio_wdata_d = win_port ? wdata1 : wdata0;
               lock_cnt_d   = 8'd0;
            end
         end

         ST_ISSUE: begin
            state_d = ST_RESP;
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            if (lock_q) begin
               // Keep ownership; the round-robin pointer stays where it is.
               locked_d = 1'b1;
               owner_d  = port_q;
            end else begin
               locked_d = 1'b0;
               prio_d   = !port_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // Single state register for the FSM and all registered outputs.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         locked_q     <= 1'b0;
         owner_q      <= 1'b0;
         lock_cnt_q   <= 8'd0;
         port_q       <= 1'b0;
         lock_q       <= 1'b0;
         mmio_en_q    <= 1'b0;
         mmio_wen_q   <= 1'b0;
         mmio_addr_q  <= 32'd0;
         mmio_wdata_q <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would chain updates in source order.
         state_q      <= state_d;
         prio_q       <= prio_d;
         locked_q     <= locked_d;
         owner_q      <= owner_d;
         lock_cnt_q   <= lock_cnt_d;
         port_q       <= port_d;
         lock_q       <= lock_d;
         mmio_en_q    <= mmio_en_d;
         mmio_wen_q   <= mmio_wen_d;
         mmio_addr_q  <= mmio_addr_d;
         mmio_wdata_q <= mmio_wdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // Grant and response strobes; both are held low while reset is asserted.
   always_comb begin
      gnt0       = grant && !win_port && !g_reset;
      gnt1       = grant &&  win_port && !g_reset;
      rsp_valid0 = in_resp && !port_q && !g_reset;
      rsp_valid1 = in_resp &&  port_q && !g_reset;
      rsp_rdata  = in_resp ? mmio_rdata : 32'd0;
      rsp_error  = in_resp ? mmio_error : 1'b0;
   end

   assign mmio_en    = mmio_en_q;
   assign mmio_wen   = mmio_wen_q;
   assign mmio_addr  = mmio_addr_q;
   assign mmio_wdata = mmio_wdata_q;

   // ------------------------------------------------------------------
   // Protocol invariants
   // ------------------------------------------------------------------
   a_no_back_to_back_en : assert property (@(posedge g_clk) disable iff (g_reset)
      mmio_en_q |=> !mmio_en_q);

   a_single_grant : assert property (@(posedge g_clk) disable iff (g_reset)
      !(gnt0 && gnt1));

   a_single_rsp : assert property (@(posedge g_clk) disable iff (g_reset)
      !(rsp_valid0 && rsp_valid1));

   a_en_only_in_issue : assert property (@(posedge g_clk) disable iff (g_reset)
      mmio_en_q == (state_q == ST_ISSUE));

endmodule
